// File: rtl/mul_acc_pkg.sv
// Shared types and width helpers for the mul_acc multiply-accumulate block.
package mul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Accumulator width: full product plus enough headroom for LEN additions.
  function automatic int acc_width(input int size, input int len);
    return 2 * size + $clog2(len);
  endfunction

  // Pair counter width: must be able to hold the value LEN itself.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mul_acc_mul.sv
// MUL: combinational unsigned array multiplier (shift-and-add of partial products).
module MUL #(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] p
);

  logic [2*SIZE-1:0] pp_a;
  logic [SIZE-1:0]   pp_b;

  // Sum one shifted copy of a for every set bit of b.
  always_comb begin
    p    = '0;
    pp_a = {{SIZE{1'b0}}, a};
    pp_b = b;
    for (int unsigned i = 0; i < unsigned'(SIZE); i++) begin
      if (pp_b[0]) begin
        p = p + pp_a;
      end
      pp_a = pp_a << 1;
      pp_b = pp_b >> 1;
    end
  end

endmodule

// File: rtl/mul_acc.sv
// mul_acc: accumulates LEN unsigned products a*b through a two-stage
// operand/product pipeline and presents the sum with a valid/ready handshake.
// Optional feature: define MUL_ACC_ABORT_EN to add the abort input.
import mul_acc_pkg::*;

module mul_acc #(
  parameter int SIZE = 8,
  parameter int LEN  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef MUL_ACC_ABORT_EN
  input  logic                              abort,
`endif
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SIZE-1:0]                   a,
  input  logic [SIZE-1:0]                   b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [acc_width(SIZE, LEN)-1:0]   result,
  output logic                              busy
);

  localparam int RW = acc_width(SIZE, LEN);
  localparam int PW = 2 * SIZE;
  localparam int CW = cnt_width(LEN);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [SIZE-1:0] a_q, a_d, b_q, b_d;
  logic            op_vld_q, op_vld_d;
  logic [PW-1:0]   prod_q, prod_d, prod_w;
  logic            prod_vld_q, prod_vld_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            accept;

  MUL #(.SIZE(SIZE)) u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod_w)
  );

  // Next-state, pipeline and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    accept      = (state_q == LOAD) && in_ready_q && in_valid;

    // Operand stage, product stage, accumulate stage.
    if (accept) begin
      a_d = a;
      b_d = b;
    end
    op_vld_d = accept;
    if (op_vld_q) begin
      prod_d = prod_w;
    end
    prod_vld_d = op_vld_q;
    if (prod_vld_q) begin
      acc_d = acc_q + RW'(prod_q);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(LEN - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      // Pairs leave the pipeline in order, so a valid product with an empty
      // operand stage is the last one being added on this edge.
      DRAIN: begin
        if (prod_vld_q && !op_vld_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef MUL_ACC_ABORT_EN
    // Abort wipes everything exactly as reset does.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      cnt_d      = '0;
      acc_d      = '0;
      a_d        = '0;
      b_d        = '0;
      op_vld_d   = 1'b0;
      prod_d     = '0;
      prod_vld_d = 1'b0;
    end
`endif

    in_ready_d  = (state_d == LOAD);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_vld_q    <= 1'b0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_vld_q    <= op_vld_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;

endmodule
